aq_djpeg_idct_sched: RTL and testbench
======================================

AQ_DJPEG_IDCT_SCHED -- requirements
Module: aq_djpeg_idct_sched

Interface
REQ-001 rst  in  1  asynchronous active-high reset.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 ProcessInit  in  1  synchronous per-image clear; samples SamplingMode.
REQ-004 SamplingMode  in  2  0=4:4:4 (3 blk/MCU), 1=4:2:2 (4), 2=4:2:0 (6), 3=gray (1).
REQ-005 BlockWrDone  in  1  pulse: producer finished filling bank BlockWrBank.
REQ-006 BlockWrBank  out  1  bank producer writes next.
REQ-007 BlockWrFull  out  1  both banks full; producer stalls.
REQ-008 IdctEnable  out  1  drives IDCT DataInEnable.
REQ-009 IdctRead  in  1  IDCT DataInRead.
REQ-010 IdctAddress  in  5  IDCT DataInAddress.
REQ-011 IdctBank  out  1  bank selected onto IDCT read port.
REQ-012 OutEnable  in  1  IDCT DataOutEnable.
REQ-013 OutPage  in  3  IDCT DataOutPage.
REQ-014 OutCount  in  2  IDCT DataOutCount.
REQ-015 BlockDone  out  1  one-cycle pulse per completed block.
REQ-016 BlockIndex  out  3  index within MCU of block just completed, valid with BlockDone.
REQ-017 McuDone  out  1  one-cycle pulse when last block of MCU completes.
REQ-018 McuCount  out  16  MCUs completed since init.
REQ-019 Idle  out  1  no bank full, no read in progress, no block in flight.
REQ-020 Error  out  1  sticky protocol-violation flag.

Function
REQ-021 State: full[1:0], wr ptr, rd ptr, reading flag, inflight counter (0..2), block index, mode register, McuCount.
REQ-022 BlockWrBank = wr ptr; BlockWrFull = full[0]&full[1]; IdctBank = rd ptr.
REQ-023 BlockWrDone with full[wr]=0: full[wr] set, wr toggles next cycle.
REQ-024 BlockWrDone with full[wr]=1: ignored, Error set.
REQ-025 IdctEnable = full[rd] & !reading & (inflight<2), combinational from registers.
REQ-026 First IdctRead cycle sets reading; IdctRead & IdctAddress==31 ends read: full[rd] cleared, rd toggles, reading cleared, inflight+1, all next cycle.
REQ-027 Release of bank X and BlockWrDone into other bank same cycle: both take effect; BlockWrFull deasserts only if result not both full.
REQ-028 Block completion = OutEnable & OutPage==7 & OutCount==3; next cycle: BlockDone=1, BlockIndex=current index, inflight-1.
REQ-029 Completion and read-end same cycle: inflight unchanged net.
REQ-030 Completion with inflight==0: no BlockDone, Error set.
REQ-031 Block index increments per completion, wraps at blocks-per-MCU minus 1; on wrap McuDone=1 same cycle as BlockDone, McuCount+1, wraps 65535->0.
REQ-032 Latency: BlockWrDone to IdctEnable 1 cycle when IDCT free; completion to BlockDone 1 cycle.
REQ-033 ProcessInit: all state to reset values next cycle, mode register loads SamplingMode; priority over every other event that cycle.
REQ-034 SamplingMode changes without ProcessInit have no effect.
REQ-035 Idle = !full[0] & !full[1] & !reading & inflight==0.

Reset
REQ-036 On rst: full=0, wr=0, rd=0, reading=0, inflight=0, index=0, mode=2, McuCount=0.
REQ-037 Outputs during/after reset: BlockWrBank=0, BlockWrFull=0, IdctEnable=0, IdctBank=0, BlockDone=0, BlockIndex=0, McuDone=0, Idle=1, Error=0.
REQ-038 rst mid-operation discards banks and in-flight blocks; no BlockDone emitted for them.

Verification
REQ-039 Single block: init mode 3, BlockWrDone -> IdctEnable next cycle, IdctBank=0; read addr 0..31; completion -> BlockDone, McuDone, McuCount=1, Idle=1.
REQ-040 Ping-pong: two BlockWrDone back-to-back -> BlockWrFull=1, third BlockWrDone -> Error=1, full unchanged.
REQ-041 4:2:0: 12 blocks -> BlockIndex 0..5 twice, McuDone on 6th and 12th, McuCount=2.
REQ-042 Throttle: three blocks queued, no completions -> IdctEnable low after 2 read-ends until a completion.
REQ-043 Simultaneous: read-end of bank 0 same cycle as BlockWrDone into bank 1 and a completion -> full={1,0}, rd=1, inflight unchanged.
REQ-044 ProcessInit mid-block with mode 0 and same-cycle BlockWrDone -> all cleared, Idle=1, next MCU wraps after 3 blocks.

Source files
------------

// File: rtl/aq_djpeg_idct_sched.sv
`default_nettype none
// ============================================================================
// Module  : aq_djpeg_idct_sched
// Brief   : Ping-pong block buffer scheduler between the coefficient producer
//           and the IDCT, tracking blocks in flight and MCU progress.
// Revision: 1.0
// ============================================================================
module aq_djpeg_idct_sched (
    input  logic        rst,
    input  logic        clk,
    input  logic        ProcessInit,
    input  logic [1:0]  SamplingMode,
    input  logic        BlockWrDone,
    output logic        BlockWrBank,
    output logic        BlockWrFull,
    output logic        IdctEnable,
    input  logic        IdctRead,
    input  logic [4:0]  IdctAddress,
    output logic        IdctBank,
    input  logic        OutEnable,
    input  logic [2:0]  OutPage,
    input  logic [1:0]  OutCount,
    output logic        BlockDone,
    output logic [2:0]  BlockIndex,
    output logic        McuDone,
    output logic [15:0] McuCount,
    output logic        Idle,
    output logic        Error
);

    localparam logic [1:0] c_MODE_DEFAULT = 2'd2;
    localparam logic [1:0] c_INFLIGHT_MAX = 2'd2;

    logic [1:0]  r_full;
    logic        r_wr;
    logic        r_rd;
    logic        r_reading;
    logic [1:0]  r_inflight;
    logic [2:0]  r_index;
    logic [1:0]  r_mode;
    logic [15:0] r_mcu_count;
    logic        r_block_done;
    logic [2:0]  r_block_index;
    logic        r_mcu_done;
    logic        r_error;

    logic [2:0]  w_bpm;
    logic        w_read_end;
    logic        w_wr_ok;
    logic        w_wr_bad;
    logic        w_cpl;
    logic        w_cpl_ok;
    logic        w_last;
    logic [1:0]  w_full_next;
    logic [1:0]  w_inflight_next;

    always_comb begin
        w_bpm = 3'd1;
        case (r_mode)
            2'd0:    w_bpm = 3'd3;
            2'd1:    w_bpm = 3'd4;
            2'd2:    w_bpm = 3'd6;
            default: w_bpm = 3'd1;
        endcase
    end

    assign w_read_end = IdctRead & (IdctAddress == 5'd31);
    assign w_wr_ok    = BlockWrDone & ~r_full[r_wr];
    assign w_wr_bad   = BlockWrDone & r_full[r_wr];
    assign w_cpl      = OutEnable & (OutPage == 3'd7) & (OutCount == 2'd3);
    assign w_cpl_ok   = w_cpl & (r_inflight != 2'd0);
    assign w_last     = (r_index == (w_bpm - 3'd1));

    // Release is applied before the write so a release and a fill of the
    // other bank in the same cycle both land.
    always_comb begin
        w_full_next = r_full;
        if (w_read_end) begin
            w_full_next[r_rd] = 1'b0;
        end
        if (w_wr_ok) begin
            w_full_next[r_wr] = 1'b1;
        end
    end

    always_comb begin
        w_inflight_next = r_inflight;
        case ({w_read_end, w_cpl_ok})
            2'b10:   w_inflight_next = r_inflight + 2'd1;
            2'b01:   w_inflight_next = r_inflight - 2'd1;
            default: w_inflight_next = r_inflight;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full        <= 2'b00;
            r_wr          <= 1'b0;
            r_rd          <= 1'b0;
            r_reading     <= 1'b0;
            r_inflight    <= 2'd0;
            r_index       <= 3'd0;
            r_mode        <= c_MODE_DEFAULT;
            r_mcu_count   <= 16'd0;
            r_block_done  <= 1'b0;
            r_block_index <= 3'd0;
            r_mcu_done    <= 1'b0;
            r_error       <= 1'b0;
        end else if (ProcessInit) begin
            r_full        <= 2'b00;
            r_wr          <= 1'b0;
            r_rd          <= 1'b0;
            r_reading     <= 1'b0;
            r_inflight    <= 2'd0;
            r_index       <= 3'd0;
            r_mode        <= SamplingMode;
            r_mcu_count   <= 16'd0;
            r_block_done  <= 1'b0;
            r_block_index <= 3'd0;
            r_mcu_done    <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_full     <= w_full_next;
            r_inflight <= w_inflight_next;
            if (w_wr_ok) begin
                r_wr <= ~r_wr;
            end
            if (w_read_end) begin
                r_rd      <= ~r_rd;
                r_reading <= 1'b0;
            end else if (IdctRead) begin
                r_reading <= 1'b1;
            end
            r_block_done <= w_cpl_ok;
            r_mcu_done   <= w_cpl_ok & w_last;
            if (w_cpl_ok) begin
                r_block_index <= r_index;
                if (w_last) begin
                    r_index     <= 3'd0;
                    r_mcu_count <= r_mcu_count + 16'd1;
                end else begin
                    r_index <= r_index + 3'd1;
                end
            end
            // A completion with nothing in flight is a protocol error, not a block.
            r_error <= r_error | w_wr_bad | (w_cpl & (r_inflight == 2'd0));
        end
    end

    assign BlockWrBank = r_wr;
    assign BlockWrFull = r_full[0] & r_full[1];
    assign IdctBank    = r_rd;
    assign IdctEnable  = r_full[r_rd] & ~r_reading & (r_inflight < c_INFLIGHT_MAX);
    assign BlockDone   = r_block_done;
    assign BlockIndex  = r_block_index;
    assign McuDone     = r_mcu_done;
    assign McuCount    = r_mcu_count;
    assign Idle        = ~r_full[0] & ~r_full[1] & ~r_reading & (r_inflight == 2'd0);
    assign Error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_aq_djpeg_idct_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_aq_djpeg_idct_sched
// Brief   : Directed scenarios plus randomized traffic against a counter-based
//           reference model of the IDCT block scheduler.
// Revision: 1.0
// ============================================================================
module tb_aq_djpeg_idct_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ProcessInit = 1'b0;
    logic [1:0]  SamplingMode = 2'd0;
    logic        BlockWrDone = 1'b0;
    logic        IdctRead = 1'b0;
    logic [4:0]  IdctAddress = 5'd0;
    logic        OutEnable = 1'b0;
    logic [2:0]  OutPage = 3'd0;
    logic [1:0]  OutCount = 2'd0;
    logic        BlockWrBank, BlockWrFull, IdctEnable, IdctBank;
    logic        BlockDone, McuDone, Idle, Error;
    logic [2:0]  BlockIndex;
    logic [15:0] McuCount;

    aq_djpeg_idct_sched dut (
        .rst(rst), .clk(clk), .ProcessInit(ProcessInit), .SamplingMode(SamplingMode),
        .BlockWrDone(BlockWrDone), .BlockWrBank(BlockWrBank), .BlockWrFull(BlockWrFull),
        .IdctEnable(IdctEnable), .IdctRead(IdctRead), .IdctAddress(IdctAddress),
        .IdctBank(IdctBank), .OutEnable(OutEnable), .OutPage(OutPage), .OutCount(OutCount),
        .BlockDone(BlockDone), .BlockIndex(BlockIndex), .McuDone(McuDone),
        .McuCount(McuCount), .Idle(Idle), .Error(Error)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: everything derives from three running block counts.
    int m_written, m_read, m_done, m_bpm, m_last_idx;
    bit m_reading, m_err, m_bdone, m_mdone;

    function automatic int bpm_of(input logic [1:0] mode);
        case (mode)
            2'd0:    return 3;
            2'd1:    return 4;
            2'd2:    return 6;
            default: return 1;
        endcase
    endfunction

    task automatic model_clear(input logic [1:0] mode);
        m_written = 0; m_read = 0; m_done = 0; m_last_idx = 0;
        m_reading = 0; m_err = 0; m_bdone = 0; m_mdone = 0;
        m_bpm = bpm_of(mode);
    endtask

    function automatic logic [26:0] exp_vec();
        int occ  = m_written - m_read;
        int infl = m_read - m_done;
        logic [15:0] mcu = 16'((m_done / m_bpm) % 65536);
        return {1'(m_written % 2), 1'(occ == 2), 1'(occ > 0 && !m_reading && infl < 2),
                1'(m_read % 2), m_bdone, 3'(m_last_idx), m_mdone, mcu,
                1'(occ == 0 && !m_reading && infl == 0), m_err};
    endfunction

    logic [26:0] dut_vec;
    assign dut_vec = {BlockWrBank, BlockWrFull, IdctEnable, IdctBank, BlockDone,
                      BlockIndex, McuDone, McuCount, Idle, Error};

    // Clocks the current inputs in, advances the model, then clears the pulses.
    task automatic tick();
        int occ, infl;
        bit rel, cpl;
        @(posedge clk);
        occ  = m_written - m_read;
        infl = m_read - m_done;
        rel  = IdctRead && IdctAddress == 5'd31;
        cpl  = OutEnable && OutPage == 3'd7 && OutCount == 2'd3;
        m_bdone = 0; m_mdone = 0;
        if (ProcessInit) begin
            model_clear(SamplingMode);
        end else begin
            if (BlockWrDone) begin
                if (occ == 2) m_err = 1; else m_written++;
            end
            if (cpl) begin
                if (infl == 0) m_err = 1;
                else begin
                    m_last_idx = m_done % m_bpm;
                    m_mdone    = (m_last_idx == m_bpm - 1);
                    m_bdone    = 1;
                    m_done++;
                end
            end
            if (rel) begin
                m_read++; m_reading = 0;
            end else if (IdctRead) begin
                m_reading = 1;
            end
        end
        #1;
        ProcessInit = 0; BlockWrDone = 0; IdctRead = 0; OutEnable = 0;
        OutPage = 3'd0; OutCount = 2'd0;
    endtask

    task automatic do_init(input logic [1:0] mode);
        ProcessInit = 1; SamplingMode = mode; tick();
    endtask

    task automatic do_write();
        BlockWrDone = 1; tick();
    endtask

    task automatic set_cpl();
        OutEnable = 1; OutPage = 3'd7; OutCount = 2'd3;
    endtask

    task automatic do_complete();
        set_cpl(); tick();
    endtask

    task automatic do_read(input int last_addr);
        for (int a = 0; a <= last_addr; a++) begin
            IdctRead = 1; IdctAddress = 5'(a); tick();
        end
    endtask

    task automatic test_reset();
        rst = 1; #12;
        model_clear(2'd2);
        if ({BlockWrBank, BlockWrFull, IdctEnable, IdctBank, BlockDone, BlockIndex, McuDone,
             McuCount, Idle, Error} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", dut_vec, exp_vec());
        end
        n_run++;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        do_init(2'd3);
        if (Idle !== 1'b1 || McuCount !== 16'd0) begin
            n_fail++; $display("FAIL single_init: Idle=%b McuCount=%0d required 1/0", Idle, McuCount);
        end
        n_run++;
        do_write();
        if (IdctEnable !== 1'b1 || IdctBank !== 1'b0) begin
            n_fail++; $display("FAIL single_enable: en=%b bank=%b required 1/0", IdctEnable, IdctBank);
        end
        n_run++;
        do_read(31);
        if (IdctEnable !== 1'b0 || Idle !== 1'b0 || BlockWrFull !== 1'b0) begin
            n_fail++; $display("FAIL single_readend: en=%b idle=%b full=%b required 0/0/0",
                               IdctEnable, Idle, BlockWrFull);
        end
        n_run++;
        do_complete();
        if ({BlockDone, McuDone, BlockIndex, McuCount, Idle} !== {1'b1, 1'b1, 3'd0, 16'd1, 1'b1}) begin
            n_fail++; $display("FAIL single_done: bd=%b md=%b idx=%0d mcu=%0d idle=%b required 1/1/0/1/1",
                               BlockDone, McuDone, BlockIndex, McuCount, Idle);
        end
        n_run++;
        tick();
        if (BlockDone !== 1'b0 || McuDone !== 1'b0) begin
            n_fail++; $display("FAIL single_pulse: bd=%b md=%b required 0/0", BlockDone, McuDone);
        end
        n_run++;
    endtask

    task automatic test_pingpong();
        do_init(2'd0);
        do_write();
        do_write();
        if (BlockWrFull !== 1'b1 || BlockWrBank !== 1'b0 || Error !== 1'b0) begin
            n_fail++; $display("FAIL pingpong_full: full=%b bank=%b err=%b required 1/0/0",
                               BlockWrFull, BlockWrBank, Error);
        end
        n_run++;
        do_write();
        if (Error !== 1'b1 || BlockWrFull !== 1'b1 || BlockWrBank !== 1'b0 || IdctEnable !== 1'b1) begin
            n_fail++; $display("FAIL pingpong_overflow: err=%b full=%b bank=%b en=%b required 1/1/0/1",
                               Error, BlockWrFull, BlockWrBank, IdctEnable);
        end
        n_run++;
    endtask

    task automatic test_420();
        do_init(2'd2);
        for (int i = 0; i < 12; i++) begin
            do_write();
            do_read(31);
            do_complete();
            if (BlockDone !== 1'b1 || BlockIndex !== 3'(i % 6) || McuDone !== 1'(i % 6 == 5)) begin
                n_fail++; $display("FAIL mode420_block%0d: bd=%b idx=%0d md=%b required 1/%0d/%0d",
                                   i, BlockDone, BlockIndex, McuDone, i % 6, (i % 6 == 5));
            end
            n_run++;
        end
        if (McuCount !== 16'd2) begin
            n_fail++; $display("FAIL mode420_mcucount: got %0d required 2", McuCount);
        end
        n_run++;
    endtask

    task automatic test_throttle();
        do_init(2'd2);
        do_write(); do_write();
        do_read(31);
        do_write();
        do_read(31);
        tick(); tick();
        if (IdctEnable !== 1'b0 || BlockWrFull !== 1'b0 || Idle !== 1'b0) begin
            n_fail++; $display("FAIL throttle_hold: en=%b full=%b idle=%b required 0/0/0",
                               IdctEnable, BlockWrFull, Idle);
        end
        n_run++;
        do_complete();
        if (IdctEnable !== 1'b1 || BlockDone !== 1'b1 || IdctBank !== 1'b0) begin
            n_fail++; $display("FAIL throttle_release: en=%b bd=%b bank=%b required 1/1/0",
                               IdctEnable, BlockDone, IdctBank);
        end
        n_run++;
    endtask

    task automatic test_simultaneous();
        do_init(2'd0);
        do_write(); do_read(31);
        do_write(); do_read(31);
        do_complete();
        do_write();
        do_read(30);
        IdctRead = 1; IdctAddress = 5'd31; BlockWrDone = 1; set_cpl();
        tick();
        if ({BlockWrFull, IdctBank, BlockWrBank, BlockDone, IdctEnable, Error} !==
            {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL simul_event: full=%b rdbank=%b wrbank=%b bd=%b en=%b err=%b required 0/1/0/1/1/0",
                               BlockWrFull, IdctBank, BlockWrBank, BlockDone, IdctEnable, Error);
        end
        n_run++;
        do_complete();
        if (BlockDone !== 1'b1 || Error !== 1'b0) begin
            n_fail++; $display("FAIL simul_inflight1: bd=%b err=%b required 1/0", BlockDone, Error);
        end
        n_run++;
        do_complete();
        if (BlockDone !== 1'b0 || Error !== 1'b1) begin
            n_fail++; $display("FAIL simul_inflight0: bd=%b err=%b required 0/1", BlockDone, Error);
        end
        n_run++;
    endtask

    task automatic test_init_priority();
        do_init(2'd2);
        do_write(); do_write();
        do_read(15);
        ProcessInit = 1; SamplingMode = 2'd0;
        BlockWrDone = 1; IdctRead = 1; IdctAddress = 5'd16; set_cpl();
        tick();
        if ({Idle, BlockWrFull, BlockWrBank, IdctEnable, Error, BlockDone} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL init_clear: idle=%b full=%b bank=%b en=%b err=%b bd=%b required 1/0/0/0/0/0",
                               Idle, BlockWrFull, BlockWrBank, IdctEnable, Error, BlockDone);
        end
        n_run++;
        for (int i = 0; i < 3; i++) begin
            do_write(); do_read(31); do_complete();
            if (McuDone !== 1'(i == 2) || BlockIndex !== 3'(i)) begin
                n_fail++; $display("FAIL init_mode444_blk%0d: md=%b idx=%0d required %0d/%0d",
                                   i, McuDone, BlockIndex, (i == 2), i);
            end
            n_run++;
        end
        if (McuCount !== 16'd1) begin
            n_fail++; $display("FAIL init_mcucount: got %0d required 1", McuCount);
        end
        n_run++;
    endtask

    task automatic test_reset_midop();
        do_init(2'd3);
        do_write(); do_read(31);
        do_write();
        rst = 1; #2;
        model_clear(2'd2);
        if (Idle !== 1'b1 || BlockWrBank !== 1'b0 || IdctBank !== 1'b0 || BlockWrFull !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: idle=%b wrbank=%b rdbank=%b full=%b required 1/0/0/0",
                               Idle, BlockWrBank, IdctBank, BlockWrFull);
        end
        n_run++;
        rst = 0;
        @(posedge clk); #1;
        do_complete();
        if (BlockDone !== 1'b0 || Error !== 1'b1) begin
            n_fail++; $display("FAIL reset_discard: bd=%b err=%b required 0/1", BlockDone, Error);
        end
        n_run++;
    endtask

    task automatic test_random();
        int addr = 0;
        bit in_read = 0;
        do_init(2'($urandom_range(0, 3)));
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int occ  = m_written - m_read;
            int infl = m_read - m_done;
            bit en   = occ > 0 && !m_reading && infl < 2;
            if ($urandom_range(0, 399) == 0) begin
                ProcessInit = 1; SamplingMode = 2'($urandom_range(0, 3));
                in_read = 0; addr = 0;
            end else begin
                if (in_read) begin
                    if ($urandom_range(0, 3) != 0) begin
                        IdctRead = 1; IdctAddress = 5'(addr);
                        if (addr == 31) begin
                            in_read = 0; addr = 0;
                        end else begin
                            addr++;
                        end
                    end
                end else if (en && $urandom_range(0, 1) == 1) begin
                    IdctRead = 1; IdctAddress = 5'd0; in_read = 1; addr = 1;
                end
            end
            if (occ < 2) BlockWrDone = ($urandom_range(0, 3) == 0);
            else         BlockWrDone = ($urandom_range(0, 199) == 0);
            if ((infl > 0 && $urandom_range(0, 15) == 0) || $urandom_range(0, 599) == 0) begin
                set_cpl();
            end else if ($urandom_range(0, 3) == 0) begin
                OutEnable = 1; OutPage = 3'($urandom_range(0, 6)); OutCount = 2'($urandom_range(0, 3));
            end
            tick();
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: outputs got %h required %h", cyc, dut_vec, exp_vec());
            end
            n_run++;
        end
    endtask

    initial begin
        model_clear(2'd2);
        test_reset();
        test_single();
        test_pingpong();
        test_420();
        test_throttle();
        test_simultaneous();
        test_init_priority();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
